// File: rtl/reg_file_2r1w_if.sv
// Request/response bundle for reg_file_2r1w: write port, two read ports, sweep-clear control.
interface reg_file_2r1w_if #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 3
);
   logic                 WrEn;
   logic [ADDR_W-1:0]    WrAddr;
   logic [WIDTH-1:0]     WrData;
   logic [WIDTH/8-1:0]   WrStrb;
   logic                 RdEnA;
   logic [ADDR_W-1:0]    RdAddrA;
   logic [WIDTH-1:0]     RdDataA;
   logic                 RdValidA;
   logic                 RdEnB;
   logic [ADDR_W-1:0]    RdAddrB;
   logic [WIDTH-1:0]     RdDataB;
   logic                 RdValidB;
   logic                 ClrReq;
   logic                 Busy;

   modport master (
      output WrEn, WrAddr, WrData, WrStrb,
      output RdEnA, RdAddrA, RdEnB, RdAddrB, ClrReq,
      input  RdDataA, RdValidA, RdDataB, RdValidB, Busy
   );

   modport slave (
      input  WrEn, WrAddr, WrData, WrStrb,
      input  RdEnA, RdAddrA, RdEnB, RdAddrB, ClrReq,
      output RdDataA, RdValidA, RdDataB, RdValidB, Busy
   );
endinterface

// File: rtl/reg_file_2r1w.sv
// Register file: one byte-strobed write port, two registered read ports with
// write-first bypass, and a one-entry-per-cycle sweep-clear engine.
module reg_file_2r1w #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 3
) (
   input logic             CLK,
   input logic             RST,
   reg_file_2r1w_if.slave  bus
);
   localparam int DEPTH  = 2**ADDR_W;
   localparam int NBYTES = WIDTH/8;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   clrCnt;
   logic [WIDTH-1:0]    mem [DEPTH];
   logic [WIDTH-1:0]    wrOld;
   logic [WIDTH-1:0]    wrMerged;
   logic [WIDTH-1:0]    rdA;
   logic [WIDTH-1:0]    rdB;

   assign wrOld = mem[bus.WrAddr];

   // Merged write word doubles as the bypass value for a same-address read.
   for (genvar g = 0; g < NBYTES; g++) begin : gMerge
      assign wrMerged[8*g +: 8] = bus.WrStrb[g] ? bus.WrData[8*g +: 8] : wrOld[8*g +: 8];
   end

   always_comb begin
      rdA = mem[bus.RdAddrA];
      rdB = mem[bus.RdAddrB];
      if (bus.WrEn && (bus.RdAddrA == bus.WrAddr)) rdA = wrMerged;
      if (bus.WrEn && (bus.RdAddrB == bus.WrAddr)) rdB = wrMerged;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[ADDR_W'(i)] <= '0;
         state        <= IDLE;
         clrCnt       <= '0;
         bus.Busy     <= 1'b0;
         bus.RdDataA  <= '0;
         bus.RdDataB  <= '0;
         bus.RdValidA <= 1'b0;
         bus.RdValidB <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.WrEn) mem[bus.WrAddr] <= wrMerged;
               bus.RdValidA <= bus.RdEnA;
               bus.RdValidB <= bus.RdEnB;
               if (bus.RdEnA) bus.RdDataA <= rdA;
               if (bus.RdEnB) bus.RdDataB <= rdB;
               if (bus.ClrReq) begin
                  state    <= CLEAR;
                  clrCnt   <= '0;
                  bus.Busy <= 1'b1;
               end
            end
            CLEAR: begin
               mem[clrCnt]  <= '0;
               clrCnt       <= clrCnt + 1'b1;
               bus.RdValidA <= 1'b0;
               bus.RdValidB <= 1'b0;
               if (clrCnt == '1) begin
                  state    <= IDLE;
                  bus.Busy <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               bus.Busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w; read responses are checked by a scoreboard
// monitor, control/status by direct checks in the stimulus thread.
module tb_reg_file_2r1w;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [15:0] qA [$];
   logic [15:0] qB [$];
   logic [15:0] fill [8] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                             16'h5555, 16'h6666, 16'h7777, 16'h8888};

   reg_file_2r1w_if #(.WIDTH(16), .ADDR_W(3)) bus ();

   reg_file_2r1w #(.WIDTH(16), .ADDR_W(3)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic quiet();
      bus.WrEn   = 1'b0;
      bus.RdEnA  = 1'b0;
      bus.RdEnB  = 1'b0;
      bus.ClrReq = 1'b0;
      bus.WrStrb = 2'b00;
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] s);
      bus.WrEn   = 1'b1;
      bus.WrAddr = a;
      bus.WrData = d;
      bus.WrStrb = s;
   endtask

   task automatic rdA(input logic [2:0] a, input logic [15:0] exp);
      bus.RdEnA   = 1'b1;
      bus.RdAddrA = a;
      qA.push_back(exp);
   endtask

   task automatic rdB(input logic [2:0] a, input logic [15:0] exp);
      bus.RdEnB   = 1'b1;
      bus.RdAddrB = a;
      qB.push_back(exp);
   endtask

   // Scoreboard monitor: every presented read response must match the next expectation.
   always @(negedge CLK) begin
      if (bus.RdValidA === 1'b1) begin
         if (qA.size() == 0) check("unexpected RdValidA", 16'h0001, 16'h0000);
         else check("RdDataA", bus.RdDataA, qA.pop_front());
      end
      if (bus.RdValidB === 1'b1) begin
         if (qB.size() == 0) check("unexpected RdValidB", 16'h0001, 16'h0000);
         else check("RdDataB", bus.RdDataB, qB.pop_front());
      end
   end

   initial begin
      quiet();
      bus.WrAddr = '0; bus.WrData = '0; bus.RdAddrA = '0; bus.RdAddrB = '0;
      cyc();
      RST = 1'b0;
      check("reset Busy", {15'b0, bus.Busy}, 16'h0000);
      check("reset RdValidA", {15'b0, bus.RdValidA}, 16'h0000);
      check("reset RdDataA", bus.RdDataA, 16'h0000);
      check("reset RdDataB", bus.RdDataB, 16'h0000);

      // reset contents all zero
      for (int i = 0; i < 8; i++) begin
         rdA(3'(i), 16'h0000);
         cyc();
      end
      quiet();
      check("idle Busy", {15'b0, bus.Busy}, 16'h0000);

      // byte merge
      wr(3'd5, 16'h000A, 2'b11); cyc(); quiet();
      rdA(3'd5, 16'h000A);       cyc(); quiet();
      wr(3'd5, 16'hBB00, 2'b10); cyc(); quiet();
      rdA(3'd5, 16'hBB0A);       cyc(); quiet();
      wr(3'd5, 16'hFFFF, 2'b00); cyc(); quiet();
      rdB(3'd5, 16'hBB0A);       cyc(); quiet();

      // bypass on A, plain read on B
      wr(3'd3, 16'h0064, 2'b11); rdA(3'd3, 16'h0064); rdB(3'd5, 16'hBB0A); cyc(); quiet();
      // partial-strobe bypass, both ports on the same address
      wr(3'd5, 16'h12CC, 2'b01); rdA(3'd5, 16'hBBCC); rdB(3'd5, 16'hBBCC); cyc(); quiet();

      // hold when not reading
      cyc();
      check("hold RdValidA", {15'b0, bus.RdValidA}, 16'h0000);
      check("hold RdDataA", bus.RdDataA, 16'hBBCC);

      // fill, then sweep; read issued with ClrReq still executes
      for (int i = 0; i < 8; i++) begin
         wr(3'(i), fill[i], 2'b11);
         cyc();
      end
      quiet();
      rdA(3'd0, 16'h1111); rdB(3'd7, 16'h8888); bus.ClrReq = 1'b1; cyc(); quiet();
      for (int k = 0; k < 8; k++) begin
         check($sformatf("sweep Busy %0d", k), {15'b0, bus.Busy}, 16'h0001);
         if (k > 0) check($sformatf("sweep RdValidA %0d", k), {15'b0, bus.RdValidA}, 16'h0000);
         wr(3'd2, 16'hFFFF, 2'b11);
         bus.RdEnA = 1'b1; bus.RdAddrA = 3'd2; bus.ClrReq = 1'b1;
         cyc();
      end
      quiet();
      check("after sweep Busy", {15'b0, bus.Busy}, 16'h0000);
      for (int i = 0; i < 8; i++) begin
         rdA(3'(i), 16'h0000);
         cyc();
      end
      quiet();

      // reset aborts a sweep in progress
      wr(3'd6, 16'hABCD, 2'b11); cyc(); quiet();
      bus.ClrReq = 1'b1; cyc(); quiet();
      cyc(); cyc();
      check("3rd sweep Busy", {15'b0, bus.Busy}, 16'h0001);
      RST = 1'b1; cyc(); RST = 1'b0;
      check("abort Busy", {15'b0, bus.Busy}, 16'h0000);
      rdA(3'd6, 16'h0000); rdB(3'd4, 16'h0000); cyc(); quiet();
      check("post-abort Busy", {15'b0, bus.Busy}, 16'h0000);
      wr(3'd7, 16'h1234, 2'b11); cyc(); quiet();
      rdA(3'd7, 16'h1234); rdB(3'd6, 16'h0000); cyc(); quiet();
      cyc(); cyc();
      check("end Busy", {15'b0, bus.Busy}, 16'h0000);
      check("pending A responses", 16'(qA.size()), 16'h0000);
      check("pending B responses", 16'(qB.size()), 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
